// File: rtl/load_store_unit.sv
// Load/store unit: turns single CPU load/store requests into word-memory accesses,
// adding byte/halfword read-modify-write, load extension and alignment errors.
module load_store_unit #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    RESP
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept  = req_valid && (state == IDLE);
  assign req_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = req_err ? RESP : SETUP;
        end
      end
      SETUP:   next_state = we_q ? WRITE : RESP;
      WRITE:   next_state = HOLD;
      HOLD:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Lane extraction and extension of the word presented by memory during SETUP.
  always_comb begin
    byte_sel  = mem_read_data[{lane_q, 3'b000} +: 8];
    half_sel  = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    load_data = mem_read_data;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_data = mem_read_data;
    endcase
  end

  // Sub-word stores keep the untouched lanes of the current memory word.
  always_comb begin
    merged = mem_read_data;
    case (size_q)
      2'b00:   merged[{lane_q, 3'b000} +: 8]   = wdata_q[7:0];
      2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'h0;
      resp_err       <= 1'b0;
      mem_addr       <= '0;
      mem_write_en   <= 1'b0;
      mem_write_data <= 32'h0;
      we_q           <= 1'b0;
      size_q         <= 2'b00;
      signed_q       <= 1'b0;
      lane_q         <= 2'b00;
      wdata_q        <= 32'h0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        lane_q   <= req_addr[1:0];
        wdata_q  <= req_wdata;
        if (!req_err) begin
          mem_addr <= req_addr[ADDR_W+1:2];
        end
      end
      if ((state == SETUP) && we_q) begin
        mem_write_data <= merged;
      end
      mem_write_en <= (state == SETUP) && we_q;
      req_ready    <= (next_state == IDLE);
      resp_valid   <= (next_state == RESP);
      if (next_state == RESP) begin
        // Only a request that goes straight from IDLE to RESP is an error.
        resp_err   <= (state == IDLE);
        resp_rdata <= ((state == SETUP) && !we_q) ? load_data : 32'h0;
      end else begin
        resp_err   <= 1'b0;
        resp_rdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases with literal expectations plus random
// traffic, all checked every cycle against a transaction-level model.
module tb_load_store_unit;
  localparam int ADDR_W = 15;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write_en;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory seen by the DUT.
  logic [31:0] ram [0:WORDS-1];
  assign mem_read_data = ram[mem_addr];
  initial begin
    for (int i = 0; i < WORDS; i++) ram[i] = i;
    forever begin
      @(posedge clk);
      if (mem_write_en) ram[mem_addr] <= mem_write_data;
    end
  end

  // ---------------- transaction-level reference model ----------------
  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] ln, input logic sg);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (int'(ln) * 8)) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (w >> (int'(ln[1]) * 16)) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] ln, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (sz == 2'b00) begin
      sh = int'(ln) * 8;
      mask = 32'hFF << sh;
      return (w & ~mask) | ((wd & 32'hFF) << sh);
    end else if (sz == 2'b01) begin
      sh = int'(ln[1]) * 16;
      mask = 32'hFFFF << sh;
      return (w & ~mask) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  logic [31:0]       mref [0:WORDS-1];
  int                m_phase = 0;   // cycles since accept, 0 = idle
  int                m_lat = 0;     // cycle (after accept) carrying the response
  logic              m_we = 1'b0;
  logic              m_err = 1'b0;
  logic [ADDR_W-1:0] m_wa = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_rdata = 32'h0;
  logic [31:0]       m_wval = 32'h0;

  initial begin
    logic [1:0] ln;
    for (int i = 0; i < WORDS; i++) mref[i] = i;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0;
        m_addr  = '0;
      end else if (m_phase != 0) begin
        if (m_we && !m_err && m_phase == 2) mref[m_wa] = m_wval;
        m_phase = (m_phase == m_lat) ? 0 : m_phase + 1;
      end else if (req_valid) begin
        ln    = req_addr[1:0];
        m_wa  = req_addr[ADDR_W+1:2];
        m_we  = req_we;
        m_err = (req_size == 2'b11) || (req_size == 2'b01 && ln[0]) ||
                (req_size == 2'b10 && ln != 2'b00);
        m_lat = m_err ? 1 : (req_we ? 4 : 2);
        m_rdata = (m_err || req_we) ? 32'h0 : load_val(mref[m_wa], req_size, ln, req_signed);
        m_wval  = store_val(mref[m_wa], req_size, ln, req_wdata);
        if (!m_err) m_addr = m_wa;
        m_phase = 1;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(m_phase == 0));
    chk("resp_valid", 32'(resp_valid), 32'(m_phase != 0 && m_phase == m_lat));
    chk("mem_write_en", 32'(mem_write_en), 32'(m_phase == 2 && m_we && !m_err));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (m_phase != 0 && m_phase == m_lat) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_err", 32'(resp_err), 32'(m_err));
    end
    if (m_phase == 2 && m_we && !m_err) chk("mem_write_data", mem_write_data, m_wval);
    if (!rst_n) begin
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", 32'(resp_err), 32'h0);
      chk("rst_wdata", mem_write_data, 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [ADDR_W+1:0] a, input logic [31:0] wd);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] rd, output logic er, output int cyc);
    cyc = 0; rd = 32'h0; er = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        cyc = k; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    if (cyc == 0) chk("resp_timeout", 32'h0, 32'h1);
  endtask

  task automatic txn(input string name, input logic we, input logic [1:0] sz, input logic sg,
                     input logic [ADDR_W+1:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    logic [31:0] rd;
    logic er;
    int cyc;
    issue(we, sz, sg, a, wd);
    wait_resp(rd, er, cyc);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_err"}, 32'(er), 32'(exp_er));
    chk({name, "_lat"}, 32'(cyc), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int cyc;
    int busy;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'h1);
    chk("reset_addr", 32'(mem_addr), 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 1: word load
    txn("ld_w", 1'b0, 2'b10, 1'b0, 17'h00014, 32'h0, 32'h00000005, 1'b0, 2);
    chk("ld_w_addr", 32'(mem_addr), 32'd5);
    // 2: byte store and loads back
    txn("st_b", 1'b1, 2'b00, 1'b0, 17'h00029, 32'h000000AB, 32'h0, 1'b0, 4);
    chk("st_b_mem", ram[10], 32'h0000AB0A);
    txn("ld_bs", 1'b0, 2'b00, 1'b1, 17'h00029, 32'h0, 32'hFFFFFFAB, 1'b0, 2);
    txn("ld_bu", 1'b0, 2'b00, 1'b0, 17'h00029, 32'h0, 32'h000000AB, 1'b0, 2);
    // 3: halfword store and loads back
    txn("st_h", 1'b1, 2'b01, 1'b0, 17'h00032, 32'h00008001, 32'h0, 1'b0, 4);
    chk("st_h_mem", ram[12], 32'h8001000C);
    txn("ld_hs", 1'b0, 2'b01, 1'b1, 17'h00032, 32'h0, 32'hFFFF8001, 1'b0, 2);
    txn("ld_hu", 1'b0, 2'b01, 1'b0, 17'h00032, 32'h0, 32'h00008001, 1'b0, 2);
    txn("ld_w12", 1'b0, 2'b10, 1'b0, 17'h00030, 32'h0, 32'h8001000C, 1'b0, 2);
    // 4: errors
    txn("err_ldw", 1'b0, 2'b10, 1'b0, 17'h00006, 32'h0, 32'h0, 1'b1, 1);
    txn("err_sth", 1'b1, 2'b01, 1'b0, 17'h00033, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    txn("err_sz3", 1'b1, 2'b11, 1'b0, 17'h00000, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    chk("err_mem12", ram[12], 32'h8001000C);
    chk("err_mem0", ram[0], 32'h0);
    chk("err_mem1", ram[1], 32'h1);

    // 5: reset during WRITE
    issue(1'b1, 2'b10, 1'b0, 17'h00050, 32'hDEADBEEF);
    @(posedge clk);
    #2 chk("rst_mid_we_before", 32'(mem_write_en), 32'h1);
    rst_n = 1'b0;
    #1 chk("rst_mid_we_after", 32'(mem_write_en), 32'h0);
    chk("rst_mid_resp", 32'(resp_valid), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk("rst_mid_ready", 32'(req_ready), 32'h1);
    txn("ld_after_rst", 1'b0, 2'b10, 1'b0, 17'h00008, 32'h0, 32'h00000002, 1'b0, 2);
    chk("rst_mid_mem", ram[20], 32'd20);

    // 6: valid held, fields toggled while busy
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 17'h00040; req_wdata = 32'h12345678;
    @(negedge clk);
    @(posedge clk);
    #1 req_we = 1'b0;
    busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) break;
      busy++;
      req_addr = 17'($urandom);
    end
    chk("hold_busy_cycles", 32'(busy), 32'd4);
    req_addr = 17'h00040;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(rd, er, cyc);
    chk("hold_ld_rdata", rd, 32'h12345678);
    chk("hold_ld_lat", 32'(cyc), 32'd2);

    // Random traffic over the first 64 words.
    for (int t = 0; t < 400; t++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom), sz, 1'($urandom), 17'($urandom_range(0, 255)), $urandom);
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < 64; i++) chk("final_mem", ram[i], mref[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
